// File: rtl/demod_mode_ctrl.sv
// Mode-switch sequencer for the demodulator bank: arbitrates manual vs. classifier requests,
// then mutes, switches, flushes and settles before releasing the gated output stream.
module demod_mode_ctrl #(
  parameter int unsigned        MODE_W        = 2,
  parameter logic [MODE_W-1:0]  DEFAULT_MODE  = '0,
  parameter int unsigned        FLUSH_CYCLES  = 256,
  parameter int unsigned        SETTLE_CYCLES = 1024,
  parameter int unsigned        HOLD_CYCLES   = 50000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     man_req,
  input  logic [MODE_W-1:0]        man_mode,
  input  logic                     auto_req,
  input  logic [MODE_W-1:0]        auto_mode,
  input  logic signed [15:0]       demod_in,
  output logic [MODE_W-1:0]        mode_select,
  output logic                     demod_flush,
  output logic                     mute,
  output logic                     busy,
  output logic                     req_ack,
  output logic [7:0]               switch_cnt,
  output logic signed [15:0]       d_out
);

  localparam logic [MODE_W-1:0] INVALID_MODE = '1;
  localparam int unsigned CNT_MAX = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DWELL_W = $clog2(HOLD_CYCLES + 2);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMute   = 2'd1,
    StFlush  = 2'd2,
    StSettle = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [MODE_W-1:0]   target_q, target_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                pend_valid_q, pend_valid_d;
  logic [MODE_W-1:0]   pend_mode_q, pend_mode_d;
  logic                sw_active_q, sw_active_d;
  logic [7:0]          switch_cnt_q, switch_cnt_d;
  logic                ack_q, ack_d;
  logic                flush_q, mute_q, busy_q;
  logic signed [15:0]  d_out_q;

  logic                man_valid;
  logic                arb_man;
  logic [MODE_W-1:0]   arb_man_mode;
  logic                auto_ok;

  // A fresh valid manual request supersedes whatever is waiting in the pending slot.
  assign man_valid    = man_req && (man_mode != INVALID_MODE);
  assign arb_man      = man_valid || pend_valid_q;
  assign arb_man_mode = man_valid ? man_mode : pend_mode_q;
  assign auto_ok      = auto_req && (auto_mode != INVALID_MODE) && (auto_mode != mode_q) &&
                        (dwell_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    target_d     = target_q;
    mode_d       = mode_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    sw_active_d  = sw_active_q;
    switch_cnt_d = switch_cnt_q;
    ack_d        = 1'b0;

    unique case (state_q)
      StRun: begin
        pend_valid_d = 1'b0;
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
        if (arb_man) begin
          ack_d = 1'b1;
          if (arb_man_mode != mode_q) begin
            target_d    = arb_man_mode;
            sw_active_d = 1'b1;
            state_d     = StMute;
          end
        end else if (auto_ok) begin
          ack_d       = 1'b1;
          target_d    = auto_mode;
          sw_active_d = 1'b1;
          state_d     = StMute;
        end
      end
      StMute: begin
        mode_d  = target_q;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        state_d = StFlush;
      end
      StFlush: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = StSettle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StRun;
          dwell_d = DWELL_W'(HOLD_CYCLES);
          // The startup sequence reaches RUN without sw_active set and so is not counted.
          if (sw_active_q) begin
            sw_active_d = 1'b0;
            if (switch_cnt_q != 8'hFF) begin
              switch_cnt_d = switch_cnt_q + 8'd1;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StFlush;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
      end
    endcase

    if ((state_q != StRun) && man_valid) begin
      pend_valid_d = 1'b1;
      pend_mode_d  = man_mode;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= StFlush;
      cnt_q        <= CNT_W'(FLUSH_CYCLES - 1);
      dwell_q      <= '0;
      target_q     <= DEFAULT_MODE;
      mode_q       <= DEFAULT_MODE;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= '0;
      sw_active_q  <= 1'b0;
      switch_cnt_q <= '0;
      ack_q        <= 1'b0;
      flush_q      <= 1'b1;
      mute_q       <= 1'b1;
      busy_q       <= 1'b1;
      d_out_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      target_q     <= target_d;
      mode_q       <= mode_d;
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      sw_active_q  <= sw_active_d;
      switch_cnt_q <= switch_cnt_d;
      ack_q        <= ack_d;
      flush_q      <= (state_d == StFlush);
      mute_q       <= (state_d != StRun);
      busy_q       <= (state_d != StRun);
      // Gate on the current state so the sample after any non-RUN cycle is an exact zero.
      d_out_q      <= (state_q == StRun) ? demod_in : 16'sd0;
    end
  end

  assign mode_select = mode_q;
  assign demod_flush = flush_q;
  assign mute        = mute_q;
  assign busy        = busy_q;
  assign req_ack     = ack_q;
  assign switch_cnt  = switch_cnt_q;
  assign d_out       = d_out_q;

endmodule

// File: tb/tb_demod_mode_ctrl.sv
// Directed bench for demod_mode_ctrl with short flush/settle/hold windows; acked requests are
// scoreboarded against the mode presented to the demodulator bank after each ack.
module tb_demod_mode_ctrl;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic               man_req;
  logic [1:0]         man_mode;
  logic               auto_req;
  logic [1:0]         auto_mode;
  logic signed [15:0] demod_in;
  logic [1:0]         mode_select;
  logic               demod_flush;
  logic               mute;
  logic               busy;
  logic               req_ack;
  logic [7:0]         switch_cnt;
  logic signed [15:0] d_out;

  demod_mode_ctrl #(
    .MODE_W       (2),
    .DEFAULT_MODE (2'b00),
    .FLUSH_CYCLES (4),
    .SETTLE_CYCLES(2),
    .HOLD_CYCLES  (10)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .man_req    (man_req),
    .man_mode   (man_mode),
    .auto_req   (auto_req),
    .auto_mode  (auto_mode),
    .demod_in   (demod_in),
    .mode_select(mode_select),
    .demod_flush(demod_flush),
    .mute       (mute),
    .busy       (busy),
    .req_ack    (req_ack),
    .switch_cnt (switch_cnt),
    .d_out      (d_out)
  );

  always #10 sys_clk = ~sys_clk;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  logic       mode_chk_pend = 1'b0;
  logic [1:0] mode_chk_val  = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every ack must match a queued expectation; the mode it carries must reach mode_select one
  // cycle later.
  always @(negedge sys_clk) begin
    if (mode_chk_pend) begin
      chk("ack_mode", 32'(mode_select), 32'(mode_chk_val));
      mode_chk_pend = 1'b0;
    end
    if (req_ack === 1'b1) begin
      chk("ack_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mode_chk_val  = exp_q.pop_front();
        mode_chk_pend = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Called in the first cycle after the reset edge.
  task automatic check_startup();
    for (int k = 1; k <= 8; k++) begin
      chk("su_mode", 32'(mode_select), 32'd0);
      chk("su_flush", 32'(demod_flush), 32'(k <= 4));
      chk("su_mute", 32'(mute), 32'(k <= 6));
      chk("su_busy", 32'(busy), 32'(k <= 6));
      chk("su_dout", 32'(d_out), (k >= 8) ? 32'd1000 : 32'd0);
      chk("su_cnt", 32'(switch_cnt), 32'd0);
      chk("su_ack", 32'(req_ack), 32'd0);
      tick();
    end
  endtask

  // Issued from a RUN cycle; returns in the first RUN cycle after the switch.
  task automatic do_switch(input logic [1:0] m, input int exp_cnt);
    man_req  = 1'b1;
    man_mode = m;
    exp_q.push_back(m);
    tick();
    man_req = 1'b0;
    repeat (7) tick();
    chk("sw_busy", 32'(busy), 32'd0);
    chk("sw_mode", 32'(mode_select), 32'(m));
    chk("sw_cnt", 32'(switch_cnt), 32'(exp_cnt));
  endtask

  initial begin
    sys_rst   = 1'b1;
    man_req   = 1'b0;
    man_mode  = 2'b00;
    auto_req  = 1'b0;
    auto_mode = 2'b00;
    demod_in  = 16'sd1000;
    repeat (3) tick();
    sys_rst = 1'b0;
    check_startup();

    // Manual switch to 10.
    man_req  = 1'b1;
    man_mode = 2'b10;
    exp_q.push_back(2'b10);
    tick();
    man_req = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      chk("m_ack", 32'(req_ack), 32'(j == 1));
      chk("m_mode", 32'(mode_select), (j >= 2) ? 32'd2 : 32'd0);
      chk("m_flush", 32'(demod_flush), 32'(j >= 2 && j <= 5));
      chk("m_mute", 32'(mute), 32'(j <= 7));
      chk("m_dout", 32'(d_out), (j >= 2) ? 32'd0 : 32'd1000);
      chk("m_cnt", 32'(switch_cnt), (j == 8) ? 32'd1 : 32'd0);
      tick();
    end

    // Held auto request is blocked until the dwell window ends (RUN entered at T+8).
    tick();
    tick();
    auto_req  = 1'b1;
    auto_mode = 2'b01;
    exp_q.push_back(2'b01);
    for (int c = 11; c <= 19; c++) begin
      chk("a_ack", 32'(req_ack), 32'(c == 19));
      tick();
    end
    for (int c = 20; c <= 45; c++) begin
      chk("a_noack", 32'(req_ack), 32'd0);
      chk("a_mode", 32'(mode_select), 32'd1);
      tick();
    end
    chk("a_cnt", 32'(switch_cnt), 32'd2);
    chk("a_busy", 32'(busy), 32'd0);
    auto_req = 1'b0;

    // Two manual requests during FLUSH: only the latest is served on return to RUN.
    man_req  = 1'b1;
    man_mode = 2'b00;
    exp_q.push_back(2'b00);
    tick();
    man_req = 1'b0;
    chk("p_ack1", 32'(req_ack), 32'd1);
    tick();
    man_req  = 1'b1;
    man_mode = 2'b01;
    tick();
    man_mode = 2'b10;
    exp_q.push_back(2'b10);
    tick();
    man_req = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      chk("p_ack", 32'(req_ack), 32'(c == 9));
      chk("p_mute", 32'(mute), 32'(c != 8));
      if (c == 8) chk("p_cnt", 32'(switch_cnt), 32'd3);
      tick();
    end
    repeat (6) tick();
    chk("p_busy", 32'(busy), 32'd0);
    chk("p_mode", 32'(mode_select), 32'd2);
    chk("p_cnt2", 32'(switch_cnt), 32'd4);

    // Same-edge manual 10 and auto 01 after the dwell expires: manual wins, auto is not queued.
    do_switch(2'b00, 5);
    repeat (11) tick();
    man_req   = 1'b1;
    man_mode  = 2'b10;
    auto_req  = 1'b1;
    auto_mode = 2'b01;
    exp_q.push_back(2'b10);
    tick();
    man_req  = 1'b0;
    auto_req = 1'b0;
    chk("s_ack", 32'(req_ack), 32'd1);
    repeat (7) tick();
    chk("s_cnt", 32'(switch_cnt), 32'd6);
    for (int i = 0; i < 12; i++) begin
      chk("s_noack", 32'(req_ack), 32'd0);
      chk("s_mode", 32'(mode_select), 32'd2);
      tick();
    end

    // Request for the current mode: acked, no switch.
    man_req  = 1'b1;
    man_mode = 2'b10;
    exp_q.push_back(2'b10);
    tick();
    man_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("e_ack", 32'(req_ack), 32'(i == 0));
      chk("e_busy", 32'(busy), 32'd0);
      chk("e_cnt", 32'(switch_cnt), 32'd6);
      tick();
    end

    // Invalid mode: ignored.
    man_req  = 1'b1;
    man_mode = 2'b11;
    tick();
    man_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("i_ack", 32'(req_ack), 32'd0);
      chk("i_busy", 32'(busy), 32'd0);
      chk("i_mode", 32'(mode_select), 32'd2);
      tick();
    end

    // Reset during SETTLE of a switch to 10, with a pending request queued in FLUSH.
    do_switch(2'b00, 7);
    man_req  = 1'b1;
    man_mode = 2'b10;
    exp_q.push_back(2'b10);
    tick();
    man_req = 1'b0;
    tick();
    tick();
    man_req  = 1'b1;
    man_mode = 2'b01;
    tick();
    man_req = 1'b0;
    repeat (3) tick();
    chk("r_settle_mute", 32'(mute), 32'd1);
    chk("r_settle_flush", 32'(demod_flush), 32'd0);
    chk("r_settle_mode", 32'(mode_select), 32'd2);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check_startup();
    for (int i = 0; i < 10; i++) begin
      chk("r_noack", 32'(req_ack), 32'd0);
      chk("r_mode", 32'(mode_select), 32'd0);
      tick();
    end

    chk("acks_outstanding", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
